// File: rtl/vid2is_frame_scheduler_pkg.sv
// Shared types and constants for the video-to-ImageStream frame scheduler.
package vid2is_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_CTRL_HDR,
        ST_CTRL_DATA,
        ST_VID_HDR,
        ST_VID_DATA,
        ST_TRUNC
    } state_t;

    localparam logic [3:0] CTRL_TYPE    = 4'hF;
    localparam logic [3:0] VID_TYPE     = 4'h0;
    localparam int         CTRL_NIBBLES = 9;

endpackage

// File: rtl/vid2is_frame_scheduler_if.sv
// Avalon-ST ImageStream source bundle (readyLatency 0).
interface vid2is_frame_scheduler_if #(
    parameter int DATA_WIDTH = 20
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  sop;
    logic                  eop;
    logic                  ready;

    modport master (output data, valid, sop, eop, input ready);
    modport slave  (input data, valid, sop, eop, output ready);
endinterface

// File: rtl/vid2is_ctrl_packet_gen.sv
// Maps a control-packet beat index onto its payload nibble; the last
// beat carries the interlace/field flags and marks end of packet.
module vid2is_ctrl_packet_gen
    import vid2is_sched_pkg::*;
(
    input  logic [15:0] width,
    input  logic [15:0] lines,
    input  logic        interlaced,
    input  logic        field,
    input  logic [3:0]  idx,
    output logic [3:0]  nibble,
    output logic        last
);

    // Width and line count go out most-significant nibble first
    always_comb begin
        nibble = 4'h0;
        case (idx)
            4'd0: nibble = width[15:12];
            4'd1: nibble = width[11:8];
            4'd2: nibble = width[7:4];
            4'd3: nibble = width[3:0];
            4'd4: nibble = lines[15:12];
            4'd5: nibble = lines[11:8];
            4'd6: nibble = lines[7:4];
            4'd7: nibble = lines[3:0];
            4'd8: nibble = {interlaced, field, 2'b00};
            default: nibble = 4'h0;
        endcase
    end

    assign last = (idx == 4'(CTRL_NIBBLES - 1));

endmodule

// File: rtl/vid2is_frame_scheduler.sv
// Outgoing sequencer: waits for a field start in the pixel FIFO, sends a
// control packet with the latched resolution, then streams the field.
// Overflow truncates the field with a single EOP beat and resynchronises.
module vid2is_frame_scheduler
    import vid2is_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 20,
    parameter int DROP_CNT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      resolution_valid,
    input  logic                      is_interlaced,
    input  logic [15:0]               active_samples,
    input  logic [15:0]               active_lines_f0,
    input  logic [15:0]               active_lines_f1,
    input  logic [DATA_WIDTH-1:0]     fifo_data,
    input  logic                      fifo_sof,
    input  logic                      fifo_field,
    input  logic                      fifo_empty,
    output logic                      fifo_rd,
    input  logic                      overflow_sticky,
    vid2is_frame_scheduler_if.master  src,
    output logic                      is_output_enable,
    output logic [DROP_CNT_WIDTH-1:0] dropped_fields
);

    state_t                state;
    logic [15:0]           lat_width;
    logic [15:0]           lat_lines;
    logic                  lat_interlaced;
    logic                  lat_field;
    logic [3:0]            beat_idx;
    logic [15:0]           sample_cnt;
    logic [15:0]           line_cnt;

    logic [15:0]           sel_lines;
    logic                  start_ok;
    logic                  sof_ready;
    logic [3:0]            ctrl_nibble;
    logic                  ctrl_last;
    logic                  last_sample;
    logic                  last_line;
    logic                  beat_valid;
    logic                  beat_sop;
    logic                  beat_eop;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  accept;

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign sel_lines   = (fifo_field & is_interlaced) ? active_lines_f1 : active_lines_f0;
    assign start_ok    = enable & resolution_valid & (active_samples != 16'd0) & (sel_lines != 16'd0);
    assign sof_ready   = ~fifo_empty & fifo_sof & ~overflow_sticky;
    assign last_sample = (sample_cnt == lat_width - 16'd1);
    assign last_line   = (line_cnt == lat_lines - 16'd1);
    assign accept      = beat_valid & src.ready;

    vid2is_ctrl_packet_gen u_ctrl (
        .width      (lat_width),
        .lines      (lat_lines),
        .interlaced (lat_interlaced),
        .field      (lat_field),
        .idx        (beat_idx),
        .nibble     (ctrl_nibble),
        .last       (ctrl_last)
    );

    // Source beat and FIFO pop decode; video beats pass straight from the FIFO head
    always_comb begin
        fifo_rd    = 1'b0;
        beat_valid = 1'b0;
        beat_sop   = 1'b0;
        beat_eop   = 1'b0;
        beat_data  = '0;
        case (state)
            ST_SYNC: fifo_rd = ~fifo_empty & ~fifo_sof;
            ST_CTRL_HDR: begin
                beat_valid     = 1'b1;
                beat_sop       = 1'b1;
                beat_data[3:0] = CTRL_TYPE;
            end
            ST_CTRL_DATA: begin
                beat_valid     = 1'b1;
                beat_eop       = ctrl_last;
                beat_data[3:0] = ctrl_nibble;
            end
            ST_VID_HDR: begin
                beat_valid     = 1'b1;
                beat_sop       = 1'b1;
                beat_data[3:0] = VID_TYPE;
            end
            ST_VID_DATA: begin
                // Overflow withholds the head word so the truncation beat ends the packet cleanly
                beat_valid = ~fifo_empty & ~overflow_sticky;
                beat_eop   = last_sample & last_line;
                beat_data  = fifo_data;
                fifo_rd    = beat_valid & src.ready;
            end
            ST_TRUNC: begin
                beat_valid = 1'b1;
                beat_eop   = 1'b1;
            end
            default: ;
        endcase
    end

    assign src.valid = beat_valid;
    assign src.sop   = beat_sop;
    assign src.eop   = beat_eop;
    assign src.data  = beat_data;

    // Packet sequencing, resolution latch, pixel/line counting and drop count
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            beat_idx         <= 4'd0;
            sample_cnt       <= 16'd0;
            line_cnt         <= 16'd0;
            dropped_fields   <= '0;
            is_output_enable <= 1'b0;
        end else begin
            is_output_enable <= (state != ST_IDLE);
            case (state)
                ST_IDLE: if (start_ok) state <= ST_SYNC;
                ST_SYNC: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (sof_ready) begin
                        lat_width      <= active_samples;
                        lat_lines      <= sel_lines;
                        lat_interlaced <= is_interlaced;
                        lat_field      <= fifo_field;
                        state          <= ST_CTRL_HDR;
                    end
                end
                ST_CTRL_HDR: if (accept) begin
                    beat_idx <= 4'd0;
                    state    <= ST_CTRL_DATA;
                end
                ST_CTRL_DATA: if (accept) begin
                    if (ctrl_last) state <= ST_VID_HDR;
                    else           beat_idx <= beat_idx + 4'd1;
                end
                ST_VID_HDR: if (accept) begin
                    sample_cnt <= 16'd0;
                    line_cnt   <= 16'd0;
                    state      <= ST_VID_DATA;
                end
                ST_VID_DATA: begin
                    if (overflow_sticky) begin
                        state <= ST_TRUNC;
                    end else if (accept) begin
                        if (beat_eop) begin
                            state <= enable ? ST_SYNC : ST_IDLE;
                        end else if (last_sample) begin
                            sample_cnt <= 16'd0;
                            line_cnt   <= line_cnt + 16'd1;
                        end else begin
                            sample_cnt <= sample_cnt + 16'd1;
                        end
                    end
                end
                ST_TRUNC: if (accept) begin
                    dropped_fields <= sat_inc(dropped_fields);
                    state          <= enable ? ST_SYNC : ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vid2is_frame_scheduler.sv
// Directed bench for the frame scheduler: a FIFO model feeds the DUT and
// an expected-beat list built from packet-format arithmetic is checked
// against every accepted source beat.
module tb_vid2is_frame_scheduler;

    localparam int DW = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          enable;
    logic          resolution_valid;
    logic          is_interlaced;
    logic [15:0]   active_samples;
    logic [15:0]   active_lines_f0;
    logic [15:0]   active_lines_f1;
    logic [DW-1:0] fifo_data;
    logic          fifo_sof;
    logic          fifo_field;
    logic          fifo_empty;
    logic          fifo_rd;
    logic          overflow_sticky;
    logic          is_output_enable;
    logic [7:0]    dropped_fields;

    vid2is_frame_scheduler_if #(.DATA_WIDTH(DW)) src_if ();

    vid2is_frame_scheduler #(.DATA_WIDTH(DW), .DROP_CNT_WIDTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .resolution_valid (resolution_valid),
        .is_interlaced    (is_interlaced),
        .active_samples   (active_samples),
        .active_lines_f0  (active_lines_f0),
        .active_lines_f1  (active_lines_f1),
        .fifo_data        (fifo_data),
        .fifo_sof         (fifo_sof),
        .fifo_field       (fifo_field),
        .fifo_empty       (fifo_empty),
        .fifo_rd          (fifo_rd),
        .overflow_sticky  (overflow_sticky),
        .src              (src_if),
        .is_output_enable (is_output_enable),
        .dropped_fields   (dropped_fields)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } beat_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sof;
        logic          field;
    } word_t;

    beat_t       exp_mem [0:255];
    int          exp_wr;
    int          exp_rd;
    word_t       fmem [0:255];
    int          f_wr;
    int          f_rd;
    logic        pop_pending;
    logic        tog_mode;
    logic        held;
    logic [31:0] held_vec;
    int          total;
    int          bad;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic exp_push(input logic [DW-1:0] d, input logic s, input logic e);
        exp_mem[exp_wr] = '{data: d, sop: s, eop: e};
        exp_wr++;
    endtask

    // Control packet: type F, width then lines as 4 nibbles MSB first, then flags
    task automatic push_ctrl(input int w, input int l, input int il, input int fld);
        exp_push(DW'(15), 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) exp_push(DW'((w >> (12 - 4 * k)) & 15), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) exp_push(DW'((l >> (12 - 4 * k)) & 15), 1'b0, 1'b0);
        exp_push(DW'(il * 8 + fld * 4), 1'b0, 1'b1);
    endtask

    // n FIFO words starting with SOF; expected video header plus the same words
    task automatic push_field(input int w, input int l, input int fld, input int n, input logic [DW-1:0] base);
        exp_push('0, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            fmem[f_wr] = '{data: base + DW'(i), sof: (i == 0), field: fld[0]};
            f_wr++;
            exp_push(base + DW'(i), 1'b0, (i == w * l - 1));
        end
    endtask

    task automatic push_junk(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fmem[f_wr] = '{data: base + DW'(i), sof: 1'b0, field: 1'b0};
            f_wr++;
        end
    endtask

    task automatic wait_exp(input int remain, input int limit, input string nm);
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            #1;
            if (exp_wr - exp_rd <= remain) break;
        end
        chk(nm, 32'(exp_wr - exp_rd), 32'(remain));
    endtask

    task automatic wait_fifo(input int limit, input string nm);
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            #1;
            if (f_rd == f_wr) break;
        end
        chk(nm, 32'(f_wr - f_rd), 32'd0);
    endtask

    task automatic compare_step();
        logic [31:0] got;
        logic [31:0] want;
        beat_t       e;
        if (rst) begin
            held = 1'b0;
        end else begin
            got = {9'd0, src_if.valid, src_if.sop, src_if.eop, src_if.data};
            if (held) chk("hold_beat", got, held_vec);
            if (src_if.valid && src_if.ready) begin
                if (exp_rd < exp_wr) begin
                    e = exp_mem[exp_rd];
                    exp_rd++;
                    want = {9'd0, 1'b1, e.sop, e.eop, e.data};
                end else begin
                    want = 32'hFFFF_FFFF;
                end
                chk("stream_beat", got, want);
            end
            held     = src_if.valid && !src_if.ready;
            held_vec = got;
        end
        pop_pending = fifo_rd;
    endtask

    task automatic drive_step();
        if (pop_pending && f_rd < f_wr) f_rd++;
        src_if.ready = tog_mode ? ~src_if.ready : 1'b1;
        if (f_rd < f_wr) begin
            fifo_empty = 1'b0;
            fifo_data  = fmem[f_rd].data;
            fifo_sof   = fmem[f_rd].sof;
            fifo_field = fmem[f_rd].field;
        end else begin
            fifo_empty = 1'b1;
            fifo_data  = '0;
            fifo_sof   = 1'b0;
            fifo_field = 1'b0;
        end
    endtask

    initial begin
        int pin1 [10] = '{15, 0, 0, 0, 4, 0, 0, 0, 2, 0};
        int mark;

        rst = 1'b1; enable = 1'b0; resolution_valid = 1'b1; is_interlaced = 1'b0;
        active_samples = 16'd4; active_lines_f0 = 16'd2; active_lines_f1 = 16'd2;
        overflow_sticky = 1'b0; tog_mode = 1'b0; src_if.ready = 1'b1;
        exp_wr = 0; exp_rd = 0; f_wr = 0; f_rd = 0; pop_pending = 1'b0;
        held = 1'b0; held_vec = '0; total = 0; bad = 0;

        // Field 1: three stale words ahead of a 4x2 progressive field
        push_junk(3, 20'hAAA00);
        push_ctrl(4, 2, 0, 0);
        push_field(4, 2, 0, 8, 20'h10000);
        for (int k = 0; k < 10; k++) chk("pin_ctrl_nibble", 32'(exp_mem[k].data), 32'(pin1[k]));
        chk("pin_ctrl_eop", 32'(exp_mem[9].eop), 32'd1);
        chk("pin_vid_hdr", {31'd0, exp_mem[10].sop}, 32'd1);
        chk("pin_vid_first", 32'(exp_mem[11].data), 32'h10000);
        chk("pin_vid_eop", {31'd0, exp_mem[18].eop}, 32'd1);
        drive_step();

        fork
            forever begin @(negedge clk); compare_step(); end
            forever begin @(posedge clk); #2; drive_step(); end
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("rst_valid", 32'(src_if.valid), 32'd0);
        chk("rst_sop", 32'(src_if.sop), 32'd0);
        chk("rst_eop", 32'(src_if.eop), 32'd0);
        chk("rst_data", 32'(src_if.data), 32'd0);
        chk("rst_oe", 32'(is_output_enable), 32'd0);
        chk("rst_dropped", 32'(dropped_fields), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        enable = 1'b1;
        wait_exp(0, 400, "t1_done");
        @(posedge clk); @(negedge clk); #1;
        chk("t1_fifo_drained", 32'(f_wr - f_rd), 32'd0);
        chk("t1_oe_active", 32'(is_output_enable), 32'd1);

        // Field 2: interlaced, F1 at the head, 3 samples x 2 lines
        is_interlaced = 1'b1; active_samples = 16'd3;
        active_lines_f0 = 16'd3; active_lines_f1 = 16'd2;
        mark = exp_wr;
        push_ctrl(3, 2, 1, 1);
        push_field(3, 2, 1, 6, 20'h20000);
        chk("pin_il_width", 32'(exp_mem[mark + 4].data), 32'd3);
        chk("pin_il_lines", 32'(exp_mem[mark + 8].data), 32'd2);
        chk("pin_il_flags", 32'(exp_mem[mark + 9].data), 32'hC);
        wait_exp(0, 400, "t2_done");

        // Field 3: ready toggling every cycle, 2x1 progressive
        is_interlaced = 1'b0; active_samples = 16'd2; active_lines_f0 = 16'd1;
        tog_mode = 1'b1;
        push_ctrl(2, 1, 0, 0);
        push_field(2, 1, 0, 2, 20'h30000);
        wait_exp(0, 400, "t3_done");
        tog_mode = 1'b0;

        // Field 4: overflow after three pixels of a 4x2 field
        active_samples = 16'd4; active_lines_f0 = 16'd2;
        push_ctrl(4, 2, 0, 0);
        push_field(4, 2, 0, 3, 20'h40000);
        exp_push('0, 1'b0, 1'b1);
        wait_exp(1, 400, "t4_pixels");
        @(posedge clk); #1;
        overflow_sticky = 1'b1;
        wait_exp(0, 50, "t4_trunc");
        @(posedge clk); @(negedge clk); #1;
        chk("t4_dropped", 32'(dropped_fields), 32'd1);
        overflow_sticky = 1'b0;
        push_junk(5, 20'h40003);
        wait_fifo(100, "t4_resync_discard");
        chk("t4_dropped_hold", 32'(dropped_fields), 32'd1);
        chk("t4_oe", 32'(is_output_enable), 32'd1);

        // Field 5: enable dropped mid-field, field still completes
        push_ctrl(4, 2, 0, 0);
        push_field(4, 2, 0, 8, 20'h50000);
        wait_exp(6, 400, "t5_mid");
        enable = 1'b0;
        wait_exp(0, 400, "t5_done");
        @(posedge clk); @(negedge clk); #1;
        chk("t5_oe_lag", 32'(is_output_enable), 32'd1);
        @(posedge clk); @(negedge clk); #1;
        chk("t5_oe_fall", 32'(is_output_enable), 32'd0);
        chk("t5_idle_valid", 32'(src_if.valid), 32'd0);
        chk("t5_fifo_drained", 32'(f_wr - f_rd), 32'd0);

        // Field 6: reset in the middle of the control packet
        enable = 1'b1;
        push_ctrl(4, 2, 0, 0);
        push_field(4, 2, 0, 8, 20'h60000);
        wait_exp(15, 400, "t6_mid");
        rst = 1'b1;
        enable = 1'b0;
        @(posedge clk); @(negedge clk); #1;
        chk("mid_rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("mid_rst_valid", 32'(src_if.valid), 32'd0);
        chk("mid_rst_sop", 32'(src_if.sop), 32'd0);
        chk("mid_rst_eop", 32'(src_if.eop), 32'd0);
        chk("mid_rst_data", 32'(src_if.data), 32'd0);
        chk("mid_rst_oe", 32'(is_output_enable), 32'd0);
        chk("mid_rst_dropped", 32'(dropped_fields), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("post_rst_valid", 32'(src_if.valid), 32'd0);
        chk("post_rst_oe", 32'(is_output_enable), 32'd0);
        chk("post_rst_fifo_rd", 32'(fifo_rd), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
